// File: rtl/multicycle_control_unit_if.sv
// Memory-port bundle between the multi-cycle controller and the shared memory.
// The controller issues the request, write qualifier and address select; the
// memory answers with a ready strobe that completes the pending access.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/
// writeback over a shared memory port, drives datapath selects and enables,
// traps illegal opcodes and counts retired instructions.
module multicycle_control_unit #(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [6:0]                 opcode,
  input  logic                       zero,
  multicycle_control_unit_if.master  mem,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic                       reg_write,
  output logic [1:0]                 alu_src_a,
  output logic [1:0]                 alu_src_b,
  output logic [1:0]                 alu_op,
  output logic [1:0]                 result_src,
  output logic                       illegal_instr,
  output logic [3:0]                 state,
  output logic [CNT_W-1:0]           instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Moore portion of the control word; the Mealy terms (ready/zero gating)
  // are applied on top through the is_fetch / is_beq flags.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       reg_write;
    logic       pc_write_uncond;
    logic       is_fetch;
    logic       is_beq;
    logic       illegal;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_op;
    logic [1:0] res;
  } ctrl_t;

  state_t           state_reg;
  state_t           state_next;
  ctrl_t            ctrl_reg;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req  = 1'b1;
        c.is_fetch = 1'b1;
        c.alu_b    = 2'b10;
        c.res      = 2'b10;
      end
      S_DECODE: begin
        c.alu_a = 2'b01;
        c.alu_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_a = 2'b10;
        c.alu_b = 2'b01;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write = 1'b1;
        c.res       = 2'b01;
      end
      S_MEMWRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_a  = 2'b10;
        c.alu_op = 2'b10;
      end
      S_EXEC_I: begin
        c.alu_a  = 2'b10;
        c.alu_b  = 2'b01;
        c.alu_op = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_a  = 2'b10;
        c.alu_op = 2'b01;
        c.is_beq = 1'b1;
      end
      S_JAL: begin
        c.alu_a           = 2'b01;
        c.alu_b           = 2'b10;
        c.pc_write_uncond = 1'b1;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection and detection of the retiring transitions.
  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:    state_next = mem.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BEQ:            state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default: begin
            // Illegal opcode: either park in TRAP or retire it as a NOP.
            if (TRAP_ON_ILLEGAL) begin
              state_next = S_TRAP;
            end else begin
              state_next = S_FETCH;
              retire     = 1'b1;
            end
          end
        endcase
      end
      // Only loads and stores reach here; bit 5 separates them.
      S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        state_next = mem.mem_ready ? S_FETCH : S_MEMWRITE;
        retire     = mem.mem_ready;
      end
      S_EXEC_R:   state_next = S_ALUWB;
      S_EXEC_I:   state_next = S_ALUWB;
      S_ALUWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_BEQ: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_JAL:      state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // State, registered control word and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      ctrl_reg    <= decode_ctrl(S_FETCH);
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= decode_ctrl(state_next);
      if (retire) begin
        instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // While reset is asserted every output is forced low, independent of the
  // registered state.
  assign mem.mem_req   = rst_n & ctrl_reg.mem_req;
  assign mem.mem_we    = rst_n & ctrl_reg.mem_we;
  assign mem.adr_src   = rst_n & ctrl_reg.adr_src;
  assign ir_write      = rst_n & ctrl_reg.is_fetch & mem.mem_ready;
  assign pc_write      = rst_n & ((ctrl_reg.is_fetch & mem.mem_ready) |
                                  (ctrl_reg.is_beq & zero) |
                                  ctrl_reg.pc_write_uncond);
  assign reg_write     = rst_n & ctrl_reg.reg_write;
  assign alu_src_a     = rst_n ? ctrl_reg.alu_a  : 2'b00;
  assign alu_src_b     = rst_n ? ctrl_reg.alu_b  : 2'b00;
  assign alu_op        = rst_n ? ctrl_reg.alu_op : 2'b00;
  assign result_src    = rst_n ? ctrl_reg.res    : 2'b00;
  assign illegal_instr = rst_n & ctrl_reg.illegal;
  assign state         = rst_n ? state_reg : 4'd0;
  assign instret       = rst_n ? instret_reg : '0;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the RV32I core, replacing the single-cycle opcode decoder. It sequences every instruction through fetch, decode, execute, memory and writeback steps over a shared memory port with a ready handshake. It drives all datapath enables and mux selects, traps illegal opcodes, and keeps a retired-instruction counter.

## Interface

- `CNT_W`, default 32: width of the retired-instruction counter.
- `TRAP_ON_ILLEGAL`, default 1: controls illegal-opcode handling.
  - 1: an illegal opcode enters TRAP and stays there.
  - 0: an illegal opcode retires as a NOP.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `zero` in 1: ALU zero flag, used by BEQ.
- `mem_ready` in 1: memory accepts or completes the current `mem_req` in this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write qualifier for `mem_req`.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: 00 = PC, 01 = oldPC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode by funct.
- `result_src` out 2: 00 = ALUOut, 01 = memory read data, 10 = ALU result.
- `illegal_instr` out 1: high while in TRAP.
- `state` out 4: current state encoding, for debug.
- `instret` out CNT_W: count of retired instructions.

## Operation

States and encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5.
- EXEC_R = 6, EXEC_I = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 11.
- Encodings 12–15 are unreachable. If entered, they go to FETCH.

Per-state outputs (anything not listed is 0):
- **FETCH**
  - `mem_req=1`, `adr_src=0`, `alu_src_a=00`, `alu_src_b=10`, `alu_op=00`, `result_src=10`.
  - `ir_write` and `pc_write` equal `mem_ready` (Mealy-gated).
  - Stays in FETCH until `mem_ready=1`, then goes to DECODE.
- **DECODE**
  - `alu_src_a=01`, `alu_src_b=01`, `alu_op=00`.
  - Next state by opcode:
    - 0000011 (load) or 0100011 (store) → MEMADR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - Any other opcode → TRAP if `TRAP_ON_ILLEGAL=1`, else FETCH.
- **MEMADR**
  - `alu_src_a=10`, `alu_src_b=01`, `alu_op=00`.
  - Load → MEMREAD; store → MEMWRITE.
  - The opcode is held stable by the IR.
- **MEMREAD**
  - `mem_req=1`, `adr_src=1`.
  - Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB**
  - `reg_write=1`, `result_src=01`.
  - Goes to FETCH.
- **MEMWRITE**
  - `mem_req=1`, `mem_we=1`, `adr_src=1`.
  - Waits for `mem_ready`, then goes to FETCH.
- **EXEC_R**
  - `alu_src_a=10`, `alu_src_b=00`, `alu_op=10`.
  - Goes to ALUWB.
- **EXEC_I**
  - `alu_src_a=10`, `alu_src_b=01`, `alu_op=10`.
  - Goes to ALUWB.
- **ALUWB**
  - `reg_write=1`, `result_src=00`.
  - Goes to FETCH.
- **BEQ**
  - `alu_src_a=10`, `alu_src_b=00`, `alu_op=01`, `result_src=00`.
  - `pc_write=zero`.
  - Goes to FETCH.
- **JAL**
  - `alu_src_a=01`, `alu_src_b=10`, `alu_op=00`, `result_src=00`, `pc_write=1`.
  - Goes to ALUWB.
- **TRAP**
  - `illegal_instr=1`. All enables are 0.
  - Stays in TRAP until reset.

Retired-instruction counter:
- `instret` increments by 1 on every edge that takes any of these transitions:
  - MEMWB → FETCH.
  - MEMWRITE → FETCH (with `mem_ready=1`).
  - ALUWB → FETCH.
  - BEQ → FETCH.
  - DECODE → FETCH (illegal-as-NOP).
- The count is unsigned modulo 2^CNT_W: all-ones wraps to 0.
- TRAP entry does not increment.

## Timing

Reset:
- While `rst_n=0` at an edge, the next state is FETCH and `instret` becomes 0.
- While `rst_n=0`, all outputs are forced to 0 combinationally, including `mem_req`; `state` reads 0.
- Reset takes priority over every transition, including a wait with `mem_req` pending and TRAP.

Memory handshake:
- `mem_req` is held high with the address stable until a cycle in which `mem_ready=1`. That edge completes the access.
- `mem_ready` is ignored when `mem_req=0`.

Cycles per instruction with zero wait states:
- load 5, store 4, R-type 4, I-type 4, JAL 4, BEQ 3.
- Each cycle of `mem_ready=0` in a memory state adds 1 cycle.

Per-edge guarantees:
- `pc_write` is high for at most one cycle per state visit. FETCH and JAL/BEQ never both write the PC in the same edge.
- `reg_write` and `mem_we` are never high in the same cycle.

## Test plan

- **Reset and idle:** hold `rst_n=0` 3 cycles, then release with `mem_ready=0` → all outputs 0 during reset. After release: `state=0`, `mem_req=1`, `ir_write=0`. Stays in FETCH 5 cycles; `instret=0`.
- **R-type, zero wait:** `opcode=0110011`, `mem_ready=1` → states 0,1,6,8,0. `ir_write` and `pc_write` pulse in the FETCH cycle; `reg_write=1` in cycle 4; `instret=1`.
- **Load with wait:** `opcode=0000011`, `mem_ready` low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. `adr_src=1` throughout MEMREAD; `result_src=01` in MEMWB.
- **Branch:** `opcode=1100011` → with `zero=1`, `pc_write=1` in BEQ; with `zero=0`, `pc_write=0`. Both cases take 3 cycles and `instret` increments.
- **Illegal opcode `0000000`:**
  - `TRAP_ON_ILLEGAL=1` → `state=11`, `illegal_instr=1` held 10 cycles with `instret` unchanged. `rst_n=0` for one edge returns to FETCH.
  - `TRAP_ON_ILLEGAL=0` → back to FETCH after DECODE and `instret` increments.
- **Counter wrap:** `CNT_W=4`, retire 17 store instructions → `instret` reads 1. Asserting `rst_n=0` mid-MEMWRITE with `mem_ready=0` gives `state=0` and `instret=0` after the edge.
